mlp_seq_ctrl: RTL and testbench
===============================

MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter N_FEAT, default 21, SHALL set the number of features per frame.
REQ-003 Parameter FEAT_W, default 4, SHALL set the unsigned width of each feature.
REQ-004 Parameter CLS_W, default 2, SHALL set the width of the class index.
REQ-005 Parameter SETTLE_CYC, default 4, SHALL set the number of cycles the classifier inputs are held stable before sampling; legal values are 1 to 255.
REQ-006 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  feature beat valid
- in_ready  out  1  feature beat accepted when in_valid is also high
- in_data  in  FEAT_W  feature value
- in_last  in  1  last feature of the frame
- core_inp  out  N_FEAT*FEAT_W  registered feature vector driving the combinational classifier
- core_out  in  CLS_W  argmax class from the classifier
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_class  out  CLS_W  registered class result
- out_err  out  1  framing error flag for the frame being presented
- busy  out  1  high in SETTLE and HOLD

Function
REQ-007 The FSM SHALL have three states: LOAD, SETTLE and HOLD.
REQ-008 in_ready SHALL be 1 only in LOAD; out_valid SHALL be 1 only in HOLD.
REQ-009 In LOAD, accepted beat k (k = 0..N_FEAT-1) SHALL be written to core_inp[FEAT_W*k+FEAT_W-1 : FEAT_W*k].
- The index counter increments by one per accepted beat.
REQ-010 An accepted beat with in_last=1 at k<N_FEAT-1 SHALL end the frame.
- The remaining features stay zero.
- An error flag is set.
REQ-011 An accepted beat at k=N_FEAT-1 SHALL end the frame regardless of in_last; if in_last=0, the error flag is set.
REQ-012 On frame end the FSM SHALL go to SETTLE.
- The settle counter loads SETTLE_CYC-1.
- The counter decrements each cycle.
REQ-013 In SETTLE with the counter at 0, the block SHALL capture core_out into out_class, capture the error flag into out_err, and go to HOLD.
- If the last beat is accepted in cycle T, out_valid is 1 from cycle T+SETTLE_CYC+1.
REQ-014 core_inp SHALL be stable throughout SETTLE and HOLD.
REQ-015 In HOLD, out_class and out_err SHALL be stable while out_ready=0.
REQ-016 When out_valid and out_ready are both 1, the block SHALL take all of the following actions in the next cycle:
- return to LOAD;
- clear core_inp, the index counter and the error flag;
- set out_valid to 0.
REQ-017 in_valid SHALL be ignored outside LOAD, with no side effects.
REQ-018 There SHALL be no overlap of frames: a new frame is accepted only after the result handshake.
REQ-019 The index counter SHALL be ceil(log2(N_FEAT)) bits wide and SHALL never exceed N_FEAT-1.
REQ-020 The settle counter SHALL be 8 bits wide.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL enter LOAD from any state, including mid-frame and mid-SETTLE.
REQ-022 Reset values SHALL be:
- in_ready=1 in the cycle after reset, and 1 from then while in LOAD;
- out_valid=0, out_class=0, out_err=0, busy=0;
- core_inp all 0;
- index counter 0, settle counter 0, error flag 0.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, default parameter constants, and the index-width function.
REQ-024 The block SHALL be purely a controller and SHALL NOT instantiate the classifier.
- The classifier connects externally via core_inp and core_out.
- One natural sub-module, mlp_seq_settle_cnt, holds the loadable down-counter with a zero flag.
REQ-025 All outputs SHALL be registered, except in_ready and busy, which are decoded from the state register.

Verification
REQ-026 Scenario: 21 beats, values k mod 16, in_last on beat 20, out_ready=1, SETTLE_CYC=4.
- core_inp[83:80]=4'h4.
- out_valid rises 5 cycles after the last accept.
- out_class equals the reference model for that vector.
- out_err=0.
REQ-027 Scenario: in_last on beat 5.
- core_inp[83:24] = 0.
- out_err=1.
- The result is presented.
REQ-028 Scenario: beat 20 accepted without in_last.
- The frame ends.
- out_err=1.
- in_ready=0 in the next cycle.
REQ-029 Scenario: out_ready held 0 for 10 cycles in HOLD while in_valid=1 and core_out toggles.
- out_class and out_err are unchanged.
- No beat is accepted.
REQ-030 Scenario: rst pulsed during SETTLE, then a new full frame.
- After the rst pulse: out_valid=0, core_inp=0, in_ready=1 the next cycle.
- The second frame classifies correctly.
REQ-031 Scenario: 50 random frames with random in_valid/out_ready gaps and SETTLE_CYC=1.
- Every result matches the model in order.
- No frame is lost or duplicated.

Source files
------------

// File: rtl/mlp_seq_ctrl_pkg.sv
// Shared definitions for the MLP sequencing controller: FSM states, default
// geometry and the feature-index width helper.
package mlp_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int DEF_N_FEAT     = 21;
    localparam int DEF_FEAT_W     = 4;
    localparam int DEF_CLS_W      = 2;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int SETTLE_W       = 8;

    // A single-feature frame still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mlp_seq_settle_cnt.sv
// Loadable 8-bit down-counter that stops at zero; zero flag is decoded from
// the count register so it is glitch-free for the controller FSM.
module mlp_seq_settle_cnt
    import mlp_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Sequencing controller for an external combinational MLP classifier:
// collects a frame of features, holds them while the classifier settles, then presents the class.
module mlp_seq_ctrl
    import mlp_seq_ctrl_pkg::*;
#(
    parameter int N_FEAT     = DEF_N_FEAT,
    parameter int FEAT_W     = DEF_FEAT_W,
    parameter int CLS_W      = DEF_CLS_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEAT_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [N_FEAT*FEAT_W-1:0] core_inp,
    input  logic [CLS_W-1:0]         core_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLS_W-1:0]         out_class,
    output logic                     out_err,
    output logic                     busy
);

    localparam int                  IDX_W       = idx_width(N_FEAT);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_FEAT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             err_flag;

    logic accept;
    logic frame_end;
    logic frame_err;
    logic capture;
    logic release_frame;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    mlp_seq_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        frame_end     = 1'b0;
        frame_err     = 1'b0;
        capture       = 1'b0;
        release_frame = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        case (state)
            ST_LOAD: begin
                accept = in_valid;
                if (in_valid) begin
                    // The last slot always closes the frame; an early in_last closes it short.
                    if (idx == IDX_LAST) begin
                        frame_end = 1'b1;
                        frame_err = ~in_last;
                    end else if (in_last) begin
                        frame_end = 1'b1;
                        frame_err = 1'b1;
                    end
                end
                if (frame_end) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    release_frame = 1'b1;
                    state_nxt     = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_inp  <= '0;
            idx       <= '0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                core_inp[int'(idx)*FEAT_W +: FEAT_W] <= in_data;
                // Index parks on the final slot so it never exceeds N_FEAT-1.
                if (!frame_end) begin
                    idx <= idx + 1'b1;
                end
                if (frame_err) begin
                    err_flag <= 1'b1;
                end
            end
            if (capture) begin
                out_class <= core_out;
                out_err   <= err_flag;
                out_valid <= 1'b1;
            end
            if (release_frame) begin
                core_inp  <= '0;
                idx       <= '0;
                err_flag  <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_SETTLE) || (state == ST_HOLD);

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl: instance A (SETTLE_CYC=4) runs directed frames,
// instance B (SETTLE_CYC=1) runs random frames with handshake gaps.
module tb_mlp_seq_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_err, a_busy;
    logic [3:0]  a_in_data;
    logic [83:0] a_core_inp;
    logic [1:0]  a_core_out, a_out_class, a_tog;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_err, b_busy;
    logic [3:0]  b_in_data;
    logic [83:0] b_core_inp;
    logic [1:0]  b_core_out, b_out_class;

    logic [2:0] a_q[$];
    logic [2:0] b_q[$];
    int         b_results;
    logic       rnd_on;
    int         last_acc;

    mlp_seq_ctrl #(.N_FEAT(21), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .core_inp(a_core_inp),
        .core_out(a_core_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_class(a_out_class), .out_err(a_out_err), .busy(a_busy)
    );

    mlp_seq_ctrl #(.N_FEAT(21), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .core_inp(b_core_inp),
        .core_out(b_core_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_class(b_out_class), .out_err(b_out_err), .busy(b_busy)
    );

    // Stand-in classifier: argmax over four interleaved feature sums, lowest index wins ties.
    function automatic logic [1:0] cls_of(input logic [83:0] v);
        int s[4];
        int best;
        for (int c = 0; c < 4; c++) s[c] = 0;
        for (int k = 0; k < 21; k++) s[k % 4] += int'(v[k*4 +: 4]);
        best = 0;
        for (int c = 1; c < 4; c++) if (s[c] > s[best]) best = c;
        return 2'(best);
    endfunction

    assign a_core_out = cls_of(a_core_inp) ^ a_tog;
    assign b_core_out = cls_of(b_core_inp);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop expected result on each output handshake.
    always @(negedge clk) begin
        if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (a_q.size() == 0) begin
                chk("a_unexpected_result", 128'({a_out_class, a_out_err}), 128'h1ff);
            end else begin
                logic [2:0] e;
                e = a_q.pop_front();
                chk("a_out_class", 128'(a_out_class), 128'(e[2:1]));
                chk("a_out_err", 128'(a_out_err), 128'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            b_results++;
            if (b_q.size() == 0) begin
                chk("b_unexpected_result", 128'({b_out_class, b_out_err}), 128'h1ff);
            end else begin
                logic [2:0] e;
                e = b_q.pop_front();
                chk("b_out_class", 128'(b_out_class), 128'(e[2:1]));
                chk("b_out_err", 128'(b_out_err), 128'(e[0]));
            end
        end
    end

    initial begin
        b_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            b_out_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic a_beat(input logic [3:0] d, input logic last);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = last;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!a_in_ready) chk("a_beat_timeout", 128'(0), 128'(1));
        last_acc = cyc;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic b_beat(input logic [3:0] d, input logic last);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = last;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!b_in_ready) chk("b_beat_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    // Waits (at negedges) for a_out_valid; returns the cycle it was first seen.
    task automatic a_wait_valid(output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 50) begin
            @(negedge clk);
            if (a_out_valid) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) chk("a_out_valid_timeout", 128'(0), 128'(1));
    endtask

    task automatic a_frame_seq(input int mode);
        // mode 0: k mod 16, last on 20; 1: 0..5 last on 5; 2: 1s with f2=9, no last; 3: as 2 with last
        for (int k = 0; k < 21; k++) begin
            if (mode == 0) a_beat(4'(k % 16), k == 20);
            else if (mode == 1) begin
                a_beat(4'(k), k == 5);
                if (k == 5) break;
            end else a_beat((k == 2) ? 4'd9 : 4'd1, (mode == 3) && (k == 20));
        end
    endtask

    initial begin
        int   at;
        logic [83:0] v1;
        int   len;
        logic lastf;
        logic [3:0] d[21];
        logic [83:0] v;
        logic err;
        int   n;

        cyc = 0; errors = 0; checks = 0; b_results = 0; rnd_on = 1'b0; last_acc = 0;
        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1; a_tog = 0;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0;
        for (int k = 0; k < 21; k++) v1[k*4 +: 4] = 4'(k % 16);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(a_in_ready), 128'(1));
        chk("rst_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_out_class", 128'(a_out_class), 128'(0));
        chk("rst_out_err", 128'(a_out_err), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_core_inp", 128'(a_core_inp), 128'(0));
        @(posedge clk); #1;

        // Full frame, good framing: class 3 (sums 28/29/34/39).
        a_q.push_back({2'd3, 1'b0});
        a_frame_seq(0);
        @(negedge clk);
        chk("f1_core_inp_top", 128'(a_core_inp[83:80]), 128'(4'h4));
        chk("f1_core_inp_all", 128'(a_core_inp), 128'(v1));
        chk("f1_busy", 128'(a_busy), 128'(1));
        a_wait_valid(at);
        chk("f1_latency", 128'(at - last_acc), 128'(5));
        @(negedge clk);
        chk("f1_post_in_ready", 128'(a_in_ready), 128'(1));
        chk("f1_post_out_valid", 128'(a_out_valid), 128'(0));
        chk("f1_post_core_inp", 128'(a_core_inp), 128'(0));
        @(posedge clk); #1;

        // Short frame ending on beat 5: class 1 (sums 4/6/2/3), error.
        a_q.push_back({2'd1, 1'b1});
        a_frame_seq(1);
        @(negedge clk);
        chk("f2_core_inp_hi_zero", 128'(a_core_inp[83:24]), 128'(0));
        chk("f2_core_inp_lo", 128'(a_core_inp[23:0]), 128'(24'h543210));
        a_wait_valid(at);
        @(posedge clk); #1;

        // 21 beats without in_last: class 2 (sums 6/5/13/5), error, in_ready drops.
        a_q.push_back({2'd2, 1'b1});
        a_frame_seq(2);
        @(negedge clk);
        chk("f3_in_ready_low", 128'(a_in_ready), 128'(0));
        a_wait_valid(at);
        @(posedge clk); #1;

        // Stall in HOLD with in_valid high and core_out toggling.
        a_out_ready = 1'b0;
        a_q.push_back({2'd3, 1'b0});
        a_frame_seq(0);
        a_wait_valid(at);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 4'hf;
            a_tog      = a_tog + 2'd1;
            @(negedge clk);
            chk("stall_out_class", 128'(a_out_class), 128'(3));
            chk("stall_out_err", 128'(a_out_err), 128'(0));
            chk("stall_in_ready", 128'(a_in_ready), 128'(0));
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_tog      = 2'd0;
        chk("stall_core_inp", 128'(a_core_inp), 128'(v1));
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset pulse during SETTLE, then a fresh good frame.
        a_frame_seq(0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", 128'(a_out_valid), 128'(0));
        chk("rstmid_core_inp", 128'(a_core_inp), 128'(0));
        chk("rstmid_in_ready", 128'(a_in_ready), 128'(1));
        chk("rstmid_busy", 128'(a_busy), 128'(0));
        @(posedge clk); #1;
        a_q.push_back({2'd2, 1'b0});
        a_frame_seq(3);
        a_wait_valid(at);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("a_queue_empty", 128'(a_q.size()), 128'(0));

        // Random frames on instance B.
        rnd_on = 1'b1;
        for (int f = 0; f < 50; f++) begin
            len   = ($urandom_range(0, 1) == 1) ? 21 : int'($urandom_range(1, 20));
            lastf = (len < 21) ? 1'b1 : ($urandom_range(0, 3) != 0);
            v = '0;
            for (int k = 0; k < 21; k++) begin
                d[k] = 4'($urandom_range(0, 15));
                if (k < len) v[k*4 +: 4] = d[k];
            end
            err = (len < 21) || !lastf;
            b_q.push_back({cls_of(v), err});
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                b_beat(d[k], (k == len - 1) ? lastf : 1'b0);
            end
        end
        n = 0;
        while (b_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        rnd_on = 1'b0;
        chk("b_queue_drained", 128'(b_q.size()), 128'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("b_result_count", 128'(b_results), 128'(50));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
